// File: rtl/rs_syndrome_calc_if.sv
// Symbol stream into the RS syndrome calculator and syndrome vector out of it.
// Handshake: din is taken on every rising edge where din_valid=1 (no ready, no backpressure);
// din_sop is meaningful only with din_valid. synd_valid and frame_err are single-cycle pulses.
interface rs_syndrome_calc_if #(
  parameter int NSYM = 16
);
  logic [7:0]        din;
  logic              din_valid;
  logic              din_sop;
  logic [8*NSYM-1:0] synd_out;
  logic              synd_valid;
  logic              err_flag;
  logic              frame_err;

  modport master (
    output din, din_valid, din_sop,
    input  synd_out, synd_valid, err_flag, frame_err
  );

  modport slave (
    input  din, din_valid, din_sop,
    output synd_out, synd_valid, err_flag, frame_err
  );
endinterface

// File: rtl/rs_syndrome_calc.sv
// RS(255,239) syndrome calculator over GF(2^8)/0x11D.
// One Horner accumulator per syndrome, evaluated at alpha^(FCR+j).
module rs_syndrome_calc #(
  parameter int N    = 255,
  parameter int NSYM = 16,
  parameter int FCR  = 0
) (
  input  logic                clk,
  input  logic                rst,
  rs_syndrome_calc_if.slave   bus,
  output logic [0:0]          state_dbg
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;
  localparam logic [7:0] LAST = 8'(N - 1);

  // With b a constant this collapses to a fixed XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] alpha_pow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 255; i++) begin
      if (i < (e % 255)) r = gf_mul(r, 8'h02);
    end
    return r;
  endfunction

  logic [0:0]        state;
  logic [7:0]        cnt;
  logic [7:0]        acc    [NSYM];
  logic [7:0]        horner [NSYM];
  logic [8*NSYM-1:0] horner_flat;
  logic [8*NSYM-1:0] synd_q;
  logic              synd_valid_q;
  logic              err_q;
  logic              frame_err_q;

  for (genvar j = 0; j < NSYM; j++) begin : g_root
    localparam logic [7:0] ROOT = alpha_pow(FCR + j);
    assign horner[j]             = gf_mul(acc[j], ROOT) ^ bus.din;
    assign horner_flat[8*j +: 8] = horner[j];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      synd_q       <= '0;
      synd_valid_q <= 1'b0;
      err_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int j = 0; j < NSYM; j++) acc[j] <= 8'h00;
    end else begin
      synd_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (bus.din_valid) begin
        case (state)
          IDLE: begin
            if (bus.din_sop) begin
              for (int j = 0; j < NSYM; j++) acc[j] <= bus.din;
              cnt   <= 8'd1;
              state <= ACC;
            end
          end
          default: begin
            if (bus.din_sop) begin
              // Early sop: drop the partial word and start over with this symbol.
              frame_err_q <= 1'b1;
              for (int j = 0; j < NSYM; j++) acc[j] <= bus.din;
              cnt <= 8'd1;
            end else begin
              for (int j = 0; j < NSYM; j++) acc[j] <= horner[j];
              if (cnt == LAST) begin
                synd_q       <= horner_flat;
                err_q        <= |horner_flat;
                synd_valid_q <= 1'b1;
                cnt          <= 8'd0;
                state        <= IDLE;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.synd_out   = synd_q;
  assign bus.synd_valid = synd_valid_q;
  assign bus.err_flag   = err_q;
  assign bus.frame_err  = frame_err_q;
  assign state_dbg      = state;

endmodule
